// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser slice.
package uniboard_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam logic [7:0] ACK_BYTE      = 8'h06;
   localparam logic [7:0] NAK_BYTE      = 8'h15;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} parser_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_SEND} reply_state_t;

   // Packet checksum: 8-bit add, carry discarded.
   function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   // Increment that sticks at 8'hFF.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_reply_sender.sv
// ACK/NAK reply sender: one pending-byte slot plus the transmitter handshake.
// Only instantiated when UART_CMD_REPLY_EN is defined.
module uart_reply_sender
   import uniboard_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       reply_valid_i,
   input  logic [7:0] reply_byte_i,
   input  logic       tx_busy_i,
   output logic [7:0] tx_data_o,
   output logic       tx_send_o
);

   reply_state_t state_q, state_d;
   logic         pend_q, pend_d;
   logic [7:0]   pbyte_q, pbyte_d;
   logic [7:0]   txd_q, txd_d;

   // State, pending slot and held transmit byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= R_IDLE;
         pend_q  <= 1'b0;
         pbyte_q <= '0;
         txd_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         pbyte_q <= pbyte_d;
         txd_q   <= txd_d;
      end
   end

   // Pending byte is overwritten by every new reply until it is copied into
   // the transmit register on entry to R_SEND; a reply arriving in that same
   // cycle is the one that gets sent.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      pbyte_d = pbyte_q;
      txd_d   = txd_q;
      if (reply_valid_i) begin
         pend_d  = 1'b1;
         pbyte_d = reply_byte_i;
      end
      case (state_q)
         R_IDLE: if (pend_d) state_d = R_WAIT;
         R_WAIT: begin
            if (!tx_busy_i) begin
               state_d = R_SEND;
               txd_d   = pbyte_d;
               pend_d  = 1'b0;
            end
         end
         R_SEND: if (tx_busy_i) state_d = R_IDLE;
         default: state_d = R_IDLE;
      endcase
   end

   assign tx_send_o = (state_q == R_SEND);
   assign tx_data_o = txd_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command packet parser: frames [SYNC, addr, data, csum], issues a
// register write strobe on a good checksum and counts checksum/timeout errors.
// Define UART_CMD_REPLY_EN to enable the ACK/NAK reply path to the transmitter.
module uart_cmd_parser
   import uniboard_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 62500,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_drdy,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data,
   output logic       reg_we,
   output logic [7:0] tx_data,
   output logic       tx_send,
   input  logic       tx_busy,
   output logic [7:0] err_count
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   parser_state_t state_q, state_d;
   logic          drdy_q;
   logic          byte_ev;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    reg_addr_q, reg_addr_d;
   logic [7:0]    reg_data_q, reg_data_d;
   logic          reg_we_q, reg_we_d;
   logic [7:0]    err_q, err_d;
   logic          reply_valid;
   logic [7:0]    reply_byte;

   assign byte_ev = rx_drdy & ~drdy_q;

   // Parser registers and drdy edge detector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         drdy_q     <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         tmo_q      <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         reg_we_q   <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         drdy_q     <= rx_drdy;
         addr_q     <= addr_d;
         data_q     <= data_d;
         tmo_q      <= tmo_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         reg_we_q   <= reg_we_d;
         err_q      <= err_d;
      end
   end

   // Packet framing, checksum and inter-byte timeout; a byte event takes
   // priority over a timeout landing in the same cycle.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      tmo_d       = tmo_q;
      reg_addr_d  = reg_addr_q;
      reg_data_d  = reg_data_q;
      reg_we_d    = 1'b0;
      err_d       = err_q;
      reply_valid = 1'b0;
      reply_byte  = ACK_BYTE;
      if (byte_ev) begin
         tmo_d = '0;
         case (state_q)
            IDLE: if (rx_data == SYNC_BYTE) state_d = ADDR;
            ADDR: begin
               addr_d  = rx_data;
               state_d = DATA;
            end
            DATA: begin
               data_d  = rx_data;
               state_d = CSUM;
            end
            CSUM: begin
               state_d     = IDLE;
               reply_valid = 1'b1;
               if (rx_data == csum8(addr_q, data_q)) begin
                  reg_addr_d = addr_q;
                  reg_data_d = data_q;
                  reg_we_d   = 1'b1;
                  reply_byte = ACK_BYTE;
               end else begin
                  err_d      = sat_inc8(err_q);
                  reply_byte = NAK_BYTE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = sat_inc8(err_q);
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   assign reg_addr  = reg_addr_q;
   assign reg_data  = reg_data_q;
   assign reg_we    = reg_we_q;
   assign err_count = err_q;

`ifdef UART_CMD_REPLY_EN
   uart_reply_sender u_reply (
      .clk           (clk),
      .reset_n       (reset_n),
      .reply_valid_i (reply_valid),
      .reply_byte_i  (reply_byte),
      .tx_busy_i     (tx_busy),
      .tx_data_o     (tx_data),
      .tx_send_o     (tx_send)
   );
`else
   logic unused_reply;
   assign unused_reply = ^{reply_valid, reply_byte, tx_busy};
   assign tx_send      = 1'b0;
   assign tx_data      = '0;
`endif

endmodule
